// File: rtl/mor1kx_wb_arbiter_cappuccino_if.sv
// Bus bundle for the writeback arbiter: four result-source handshakes plus the
// registered register-file write port.
interface mor1kx_wb_arbiter_cappuccino_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
);
  logic                            flush_i;

  logic                            alu_valid_i;
  logic [OPTION_OPERAND_WIDTH-1:0] alu_result_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] alu_rfd_i;
  logic                            alu_ready_o;

  logic                            mul_valid_i;
  logic [OPTION_OPERAND_WIDTH-1:0] mul_result_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] mul_rfd_i;
  logic                            mul_ready_o;

  logic                            lsu_valid_i;
  logic [OPTION_OPERAND_WIDTH-1:0] lsu_result_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] lsu_rfd_i;
  logic                            lsu_ready_o;

  logic                            spr_valid_i;
  logic [OPTION_OPERAND_WIDTH-1:0] spr_result_i;
  logic [OPTION_RF_ADDR_WIDTH-1:0] spr_rfd_i;
  logic                            spr_ready_o;

  logic                            rf_we_o;
  logic [OPTION_RF_ADDR_WIDTH-1:0] rf_addr_o;
  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_o;
  logic [1:0]                      wb_src_o;
  logic                            busy_o;

  // Arbiter side.
  modport slave (
    input  flush_i,
    input  alu_valid_i, alu_result_i, alu_rfd_i,
    input  mul_valid_i, mul_result_i, mul_rfd_i,
    input  lsu_valid_i, lsu_result_i, lsu_rfd_i,
    input  spr_valid_i, spr_result_i, spr_rfd_i,
    output alu_ready_o, mul_ready_o, lsu_ready_o, spr_ready_o,
    output rf_we_o, rf_addr_o, rf_result_o, wb_src_o, busy_o
  );

  // Pipeline / register-file side.
  modport master (
    output flush_i,
    output alu_valid_i, alu_result_i, alu_rfd_i,
    output mul_valid_i, mul_result_i, mul_rfd_i,
    output lsu_valid_i, lsu_result_i, lsu_rfd_i,
    output spr_valid_i, spr_result_i, spr_rfd_i,
    input  alu_ready_o, mul_ready_o, lsu_ready_o, spr_ready_o,
    input  rf_we_o, rf_addr_o, rf_result_o, wb_src_o, busy_o
  );
endinterface

// File: rtl/mor1kx_wb_arbiter_cappuccino.sv
// Register-file writeback arbiter: one holding buffer per result source, fixed
// priority LSU > MUL > SPR > ALU with starvation aging, registered RF write port.
module mor1kx_wb_arbiter_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5,
  parameter int STARVE_LIMIT         = 4
) (
  input logic                          clk,
  input logic                          rst,
  mor1kx_wb_arbiter_cappuccino_if.slave bus
);

  // Source index doubles as wb_src_o encoding and as priority (lower wins).
  localparam int         NSRC    = 4;
  localparam logic [1:0] SRC_LSU = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_SPR = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd3;
  localparam int         CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(STARVE_LIMIT);

  typedef logic [OPTION_OPERAND_WIDTH-1:0] data_t;
  typedef logic [OPTION_RF_ADDR_WIDTH-1:0] rfd_t;

  logic [NSRC-1:0] in_valid;
  data_t           in_data [NSRC];
  rfd_t            in_rfd  [NSRC];

  logic [NSRC-1:0] buf_valid_q, buf_valid_d;
  data_t           buf_data_q  [NSRC];
  data_t           buf_data_d  [NSRC];
  rfd_t            buf_rfd_q   [NSRC];
  rfd_t            buf_rfd_d   [NSRC];
  logic [CW-1:0]   wait_q      [NSRC];
  logic [CW-1:0]   wait_d      [NSRC];

  logic            rf_we_q,     rf_we_d;
  rfd_t            rf_addr_q,   rf_addr_d;
  data_t           rf_result_q, rf_result_d;
  logic [1:0]      wb_src_q,    wb_src_d;

  logic [NSRC-1:0] urgent;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] grant;
  logic [NSRC-1:0] ready;
  logic [1:0]      win;
  logic            any_grant;

  assign in_valid[SRC_LSU] = bus.lsu_valid_i;
  assign in_valid[SRC_MUL] = bus.mul_valid_i;
  assign in_valid[SRC_SPR] = bus.spr_valid_i;
  assign in_valid[SRC_ALU] = bus.alu_valid_i;

  assign in_data[SRC_LSU]  = bus.lsu_result_i;
  assign in_data[SRC_MUL]  = bus.mul_result_i;
  assign in_data[SRC_SPR]  = bus.spr_result_i;
  assign in_data[SRC_ALU]  = bus.alu_result_i;

  assign in_rfd[SRC_LSU]   = bus.lsu_rfd_i;
  assign in_rfd[SRC_MUL]   = bus.mul_rfd_i;
  assign in_rfd[SRC_SPR]   = bus.spr_rfd_i;
  assign in_rfd[SRC_ALU]   = bus.alu_rfd_i;

  // Arbitration looks only at stored state, so ready never depends on valid_i.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    urgent = '0;
    win    = SRC_LSU;
    for (int s = 0; s < NSRC; s++) begin
      urgent[s] = buf_valid_q[s] && (wait_q[s] == WAIT_MAX);
    end
    cand      = (|urgent) ? urgent : buf_valid_q;
    any_grant = |cand;
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (cand[s]) win = 2'(s);
    end
    grant = any_grant ? (NSRC'(1) << win) : '0;
    ready = {NSRC{~bus.flush_i}} & (~buf_valid_q | grant);
  end

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_rfd_d   = buf_rfd_q;
    wait_d      = wait_q;
    for (int s = 0; s < NSRC; s++) begin
      if (bus.flush_i) begin
        buf_valid_d[s] = 1'b0;
        wait_d[s]      = '0;
      end else if (in_valid[s] && ready[s]) begin
        buf_valid_d[s] = 1'b1;
        buf_data_d[s]  = in_data[s];
        buf_rfd_d[s]   = in_rfd[s];
        wait_d[s]      = '0;
      end else if (grant[s]) begin
        buf_valid_d[s] = 1'b0;
        wait_d[s]      = '0;
      end else if (buf_valid_q[s] && (wait_q[s] != WAIT_MAX)) begin
        wait_d[s]      = wait_q[s] + CW'(1);
      end
    end
  end

  // r0 results drain through the arbiter but never raise the write enable.
  always_comb begin
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_result_d = rf_result_q;
    wb_src_d    = wb_src_q;
    if (!bus.flush_i && any_grant) begin
      rf_we_d     = |buf_rfd_q[win];
      rf_addr_d   = buf_rfd_q[win];
      rf_result_d = buf_data_q[win];
      wb_src_d    = win;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: buffer payloads are reset along with their valid bits so the
      // observable state after reset is fully zero, not just "empty".
      buf_valid_q <= '0;
      for (int s = 0; s < NSRC; s++) begin
        buf_data_q[s] <= '0;
        buf_rfd_q[s]  <= '0;
        wait_q[s]     <= '0;
      end
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_result_q <= '0;
      wb_src_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      buf_rfd_q   <= buf_rfd_d;
      wait_q      <= wait_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_result_q <= rf_result_d;
      wb_src_q    <= wb_src_d;
    end
  end

  assign bus.lsu_ready_o = ready[SRC_LSU];
  assign bus.mul_ready_o = ready[SRC_MUL];
  assign bus.spr_ready_o = ready[SRC_SPR];
  assign bus.alu_ready_o = ready[SRC_ALU];

  assign bus.rf_we_o     = rf_we_q;
  assign bus.rf_addr_o   = rf_addr_q;
  assign bus.rf_result_o = rf_result_q;
  assign bus.wb_src_o    = wb_src_q;
  assign bus.busy_o      = |buf_valid_q;

endmodule

// File: tb/tb_mor1kx_wb_arbiter_cappuccino.sv
// Directed bench for the writeback arbiter: latency, priority, aging, r0,
// flush and asynchronous reset, all with hand-computed expectations.
module tb_mor1kx_wb_arbiter_cappuccino;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  mor1kx_wb_arbiter_cappuccino_if #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) bus ();

  mor1kx_wb_arbiter_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5),
    .STARVE_LIMIT        (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush_i      = 1'b0;
    bus.alu_valid_i  = 1'b0; bus.alu_result_i = '0; bus.alu_rfd_i = '0;
    bus.mul_valid_i  = 1'b0; bus.mul_result_i = '0; bus.mul_rfd_i = '0;
    bus.lsu_valid_i  = 1'b0; bus.lsu_result_i = '0; bus.lsu_rfd_i = '0;
    bus.spr_valid_i  = 1'b0; bus.spr_result_i = '0; bus.spr_rfd_i = '0;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] addr,
                             input logic [31:0] data, input logic [1:0] src);
    check({tag, ".we"},   64'(bus.rf_we_o),     64'(we));
    check({tag, ".addr"}, 64'(bus.rf_addr_o),   64'(addr));
    check({tag, ".data"}, 64'(bus.rf_result_o), 64'(data));
    check({tag, ".src"},  64'(bus.wb_src_o),    64'(src));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    idle_inputs();

    // Reset state
    #12;
    check_write("rst", 1'b0, 5'd0, 32'd0, 2'd0);
    check("rst.busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b1;
    tick();
    check("idle.alu_ready", 64'(bus.alu_ready_o), 64'd1);

    // 1: single ALU result, one-cycle latency
    bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd3; bus.alu_result_i = 32'h1234_5678;
    tick();
    bus.alu_valid_i = 1'b0;
    check("t1.e0.we", 64'(bus.rf_we_o), 64'd0);
    check("t1.e0.busy", 64'(bus.busy_o), 64'd1);
    tick();
    check_write("t1.e1", 1'b1, 5'd3, 32'h1234_5678, 2'd3);
    check("t1.e1.busy", 64'(bus.busy_o), 64'd0);
    tick();
    check_write("t1.e2", 1'b0, 5'd3, 32'h1234_5678, 2'd3);

    // 2: LSU beats ALU, neither result lost
    bus.lsu_valid_i = 1'b1; bus.lsu_rfd_i = 5'd4; bus.lsu_result_i = 32'hA;
    bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd5; bus.alu_result_i = 32'hB;
    tick();
    idle_inputs();
    tick();
    check_write("t2.e1", 1'b1, 5'd4, 32'hA, 2'd0);
    check("t2.e1.busy", 64'(bus.busy_o), 64'd1);
    tick();
    check_write("t2.e2", 1'b1, 5'd5, 32'hB, 2'd3);
    tick();
    check("t2.e3.we", 64'(bus.rf_we_o), 64'd0);

    // 3: ALU starved by a continuous LSU stream until it turns urgent
    bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd7; bus.alu_result_i = 32'h77;
    bus.lsu_valid_i = 1'b1; bus.lsu_rfd_i = 5'd9;
    for (int k = 0; k <= 4; k++) begin
      bus.lsu_result_i = 32'h100 + 32'(k);
      tick();
      if (k == 0) bus.alu_valid_i = 1'b0;
      if (k >= 1) check_write($sformatf("t3.e%0d", k), 1'b1, 5'd9, 32'h100 + 32'(k - 1), 2'd0);
    end
    check("t3.e4.lsu_ready", 64'(bus.lsu_ready_o), 64'd0);
    check("t3.e4.alu_ready", 64'(bus.alu_ready_o), 64'd1);
    tick();
    bus.lsu_valid_i = 1'b0;
    check_write("t3.e5", 1'b1, 5'd7, 32'h77, 2'd3);
    tick();
    check_write("t3.e6", 1'b1, 5'd9, 32'h104, 2'd0);
    tick();
    check("t3.e7.we", 64'(bus.rf_we_o), 64'd0);
    check("t3.e7.busy", 64'(bus.busy_o), 64'd0);

    // 4: r0 write drains without enabling the RF
    bus.spr_valid_i = 1'b1; bus.spr_rfd_i = 5'd0; bus.spr_result_i = 32'hDEAD;
    tick();
    bus.spr_valid_i = 1'b0;
    check("t4.e0.busy", 64'(bus.busy_o), 64'd1);
    check("t4.e0.spr_ready", 64'(bus.spr_ready_o), 64'd1);
    tick();
    check_write("t4.e1", 1'b0, 5'd0, 32'hDEAD, 2'd2);
    check("t4.e1.busy", 64'(bus.busy_o), 64'd0);
    check("t4.e1.spr_ready", 64'(bus.spr_ready_o), 64'd1);

    // 5: flush discards buffered results and blocks same-cycle acceptance
    bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd1; bus.alu_result_i = 32'h11;
    bus.mul_valid_i = 1'b1; bus.mul_rfd_i = 5'd2; bus.mul_result_i = 32'h22;
    bus.spr_valid_i = 1'b1; bus.spr_rfd_i = 5'd3; bus.spr_result_i = 32'h33;
    tick();
    idle_inputs();
    check("t5.e0.busy", 64'(bus.busy_o), 64'd1);
    bus.flush_i = 1'b1;
    bus.lsu_valid_i = 1'b1; bus.lsu_rfd_i = 5'd10; bus.lsu_result_i = 32'h44;
    #1;
    check("t5.flush.lsu_ready", 64'(bus.lsu_ready_o), 64'd0);
    tick();
    idle_inputs();
    check_write("t5.e1", 1'b0, 5'd0, 32'hDEAD, 2'd2);
    check("t5.e1.busy", 64'(bus.busy_o), 64'd0);
    tick();
    check("t5.e2.we", 64'(bus.rf_we_o), 64'd0);

    // 6: asynchronous reset between edges drops two pending results
    bus.lsu_valid_i = 1'b1; bus.lsu_rfd_i = 5'd8;  bus.lsu_result_i = 32'h88;
    bus.mul_valid_i = 1'b1; bus.mul_rfd_i = 5'd12; bus.mul_result_i = 32'hCC;
    bus.alu_valid_i = 1'b1; bus.alu_rfd_i = 5'd6;  bus.alu_result_i = 32'h66;
    tick();
    idle_inputs();
    tick();
    check_write("t6.e1", 1'b1, 5'd8, 32'h88, 2'd0);
    check("t6.e1.busy", 64'(bus.busy_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check_write("t6.rst", 1'b0, 5'd0, 32'd0, 2'd0);
    check("t6.rst.busy", 64'(bus.busy_o), 64'd0);
    #2;
    rst = 1'b1;
    tick();
    check("t6.post1.we", 64'(bus.rf_we_o), 64'd0);
    tick();
    check("t6.post2.we", 64'(bus.rf_we_o), 64'd0);
    check("t6.post2.busy", 64'(bus.busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
